// File: rtl/biu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// biu_pkg : shared types, defaults and segment:offset address helper
// Rev 1.0
// ---------------------------------------------------------------------------
package biu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } biu_state_e;

    typedef enum logic {
        leer     = 1'b0,
        escribir = 1'b1
    } rd_wr_e;

    localparam int          QUEUE_DEPTH_DEF = 4;
    localparam logic [15:0] CS_RESET_DEF    = 16'hFFFF;
    localparam logic [15:0] IP_RESET_DEF    = 16'h0000;

    // 20-bit sum wraps naturally at 1 MiB
    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
        return {seg, 4'b0000} + {4'b0000, off};
    endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prefetch_queue : circular byte buffer holding prefetched instruction bytes
// Rev 1.0
// ---------------------------------------------------------------------------
module prefetch_queue
    import biu_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_wdata,
    input  logic       i_pop,
    input  logic       i_flush,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic [2:0] o_count
);
    localparam int         c_PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] c_DEPTH = 3'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_PW-1:0] r_head, r_tail;
    logic [2:0]      r_count;
    logic            w_do_push, w_do_pop;

    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    assign w_do_push = i_push && (r_count != c_DEPTH);
    assign w_do_pop  = i_pop  && (r_count != 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 3'd0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 3'd0;
        end else begin
            if (w_do_push) r_tail <= ptr_inc(r_tail);
            if (w_do_pop)  r_head <= ptr_inc(r_head);
            r_count <= r_count + 3'(w_do_push) - 3'(w_do_pop);
        end
    end

    // Storage needs no reset: the head byte is masked while the queue is empty
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_tail] <= i_wdata;
    end

    assign o_byte  = (r_count != 3'd0) ? r_mem[r_head] : 8'h00;
    assign o_valid = (r_count != 3'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/biu_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// biu_controller : 8088 bus interface unit - byte bus cycles, EU/prefetch arbitration
// Rev 1.0
// ---------------------------------------------------------------------------
module biu_controller
    import biu_pkg::*;
#(
    parameter int          QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter logic [15:0] CS_RESET    = CS_RESET_DEF,
    parameter logic [15:0] IP_RESET    = IP_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eu_req,
    input  logic        eu_rd_wr,
    input  logic        eu_word,
    input  logic [15:0] eu_segment,
    input  logic [15:0] eu_offset,
    input  logic [15:0] eu_wdata,
    output logic        eu_ack,
    output logic [15:0] eu_rdata,
    input  logic        flush,
    input  logic [15:0] new_cs,
    input  logic [15:0] new_ip,
    input  logic        q_pop,
    output logic [7:0]  q_byte,
    output logic        q_valid,
    output logic [2:0]  q_count,
    output logic [19:0] bus_addr,
    output logic        bus_en,
    output logic        bus_rd_wr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ready
);
    localparam logic [2:0] c_DEPTH = 3'(QUEUE_DEPTH);

    biu_state_e  r_state, w_state_nxt;
    rd_wr_e      r_rd_wr;
    logic        r_is_eu, r_word, r_hi, r_discard, r_eu_ack;
    logic [15:0] r_seg, r_off, r_cs, r_ip, r_eu_rdata;
    logic [19:0] r_addr;
    logic [7:0]  r_wdata, r_wdata_hi, r_lo_byte;
    logic        w_eu_go, w_pf_go, w_lo_done, w_done, w_push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // The EU request is still held during its own ack cycle, so it is masked there
    always_comb begin
        w_state_nxt = r_state;
        w_eu_go     = 1'b0;
        w_pf_go     = 1'b0;
        w_lo_done   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (eu_req && !r_eu_ack) begin
                    w_eu_go     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end else if (q_count < c_DEPTH) begin
                    w_pf_go     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: w_state_nxt = ST_DATA;
            ST_DATA: begin
                if (bus_ready) begin
                    if (r_word && !r_hi) begin
                        w_lo_done   = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_push = w_done && !r_is_eu && !r_discard && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_wr    <= leer;
            r_is_eu    <= 1'b0;
            r_word     <= 1'b0;
            r_hi       <= 1'b0;
            r_discard  <= 1'b0;
            r_eu_ack   <= 1'b0;
            r_seg      <= 16'h0000;
            r_off      <= 16'h0000;
            r_cs       <= CS_RESET;
            r_ip       <= IP_RESET;
            r_eu_rdata <= 16'h0000;
            r_addr     <= 20'h00000;
            r_wdata    <= 8'h00;
            r_wdata_hi <= 8'h00;
            r_lo_byte  <= 8'h00;
        end else begin
            r_eu_ack <= 1'b0;
            if (w_eu_go) begin
                r_is_eu    <= 1'b1;
                r_word     <= eu_word;
                r_hi       <= 1'b0;
                r_rd_wr    <= rd_wr_e'(eu_rd_wr);
                r_seg      <= eu_segment;
                r_off      <= eu_offset;
                r_addr     <= phys_addr(eu_segment, eu_offset);
                r_wdata    <= eu_wdata[7:0];
                r_wdata_hi <= eu_wdata[15:8];
                r_discard  <= 1'b0;
            end else if (w_pf_go) begin
                r_is_eu   <= 1'b0;
                r_word    <= 1'b0;
                r_hi      <= 1'b0;
                r_rd_wr   <= leer;
                r_addr    <= phys_addr(r_cs, r_ip);
                r_wdata   <= 8'h00;
                r_discard <= flush;
            end
            if (w_lo_done) begin
                r_hi      <= 1'b1;
                r_lo_byte <= bus_rdata;
                r_addr    <= phys_addr(r_seg, r_off + 16'd1);
                r_wdata   <= r_wdata_hi;
            end
            if (w_done && r_is_eu) begin
                r_eu_ack <= 1'b1;
                if (r_rd_wr == leer)
                    r_eu_rdata <= r_word ? {bus_rdata, r_lo_byte} : {8'h00, bus_rdata};
            end
            // A prefetch already on the bus completes but its byte must not land
            if (flush) begin
                r_cs <= new_cs;
                r_ip <= new_ip;
                if (r_state != ST_IDLE && !r_is_eu) r_discard <= 1'b1;
            end else if (w_push) begin
                r_ip <= r_ip + 16'd1;
            end
        end
    end

    prefetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (bus_rdata),
        .i_pop   (q_pop),
        .i_flush (flush),
        .o_byte  (q_byte),
        .o_valid (q_valid),
        .o_count (q_count)
    );

    assign eu_ack    = r_eu_ack;
    assign eu_rdata  = r_eu_rdata;
    assign bus_en    = (r_state != ST_IDLE);
    assign bus_addr  = r_addr;
    assign bus_rd_wr = r_rd_wr;
    assign bus_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_biu_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_biu_controller : directed scenarios plus randomized EU/prefetch traffic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_biu_controller;

    logic        clk, reset, eu_req, eu_rd_wr, eu_word, eu_ack, flush, q_pop, q_valid;
    logic [15:0] eu_segment, eu_offset, eu_wdata, eu_rdata, new_cs, new_ip;
    logic [7:0]  q_byte, bus_wdata, bus_rdata;
    logic [2:0]  q_count;
    logic [19:0] bus_addr;
    logic        bus_en, bus_rd_wr, bus_ready;

    biu_controller dut (
        .clk(clk), .reset(reset), .eu_req(eu_req), .eu_rd_wr(eu_rd_wr), .eu_word(eu_word),
        .eu_segment(eu_segment), .eu_offset(eu_offset), .eu_wdata(eu_wdata),
        .eu_ack(eu_ack), .eu_rdata(eu_rdata), .flush(flush), .new_cs(new_cs), .new_ip(new_ip),
        .q_pop(q_pop), .q_byte(q_byte), .q_valid(q_valid), .q_count(q_count),
        .bus_addr(bus_addr), .bus_en(bus_en), .bus_rd_wr(bus_rd_wr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

    typedef struct {
        logic [19:0] addr;
        logic        wr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } xact_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  seed8;
    logic [7:0]  ovr [int];
    xact_t       blog [$];
    int          phase;
    bit          rdy_force;
    logic        rdy_val;
    logic [15:0] m_cs, m_ip;

    // Memory contents: a fixed pseudo-random image with a few pinned bytes
    function automatic logic [7:0] memf(input logic [19:0] a);
        if (ovr.exists(int'(a))) return ovr[int'(a)];
        return 8'(a ^ (a >> 7) ^ (a >> 13)) ^ seed8;
    endfunction

    function automatic logic [19:0] addr_of(input logic [15:0] s, input logic [15:0] o);
        int unsigned v;
        v = 32'(s) * 32'd16 + 32'(o);
        return v[19:0];
    endfunction

    assign bus_rdata = memf(bus_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Completed bus cycles: first bus_en cycle is ADDR, completion is DATA with ready
    initial begin
        xact_t x;
        phase = 0;
        forever begin
            @(negedge clk);
            if (!reset || !bus_en) phase = 0;
            else if (phase == 0) phase = 1;
            else if (bus_ready) begin
                x.addr = bus_addr; x.wr = bus_rd_wr; x.wdata = bus_wdata; x.rdata = bus_rdata;
                blog.push_back(x);
                phase = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_full(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (q_count == 3'd4) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick(2);
        n_cmp++;
        if ({bus_en, eu_ack, q_valid, bus_rd_wr} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {bus_en, eu_ack, q_valid, bus_rd_wr});
        end
        n_cmp++;
        if ({q_count, q_byte} !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_queue: count %0d byte %h want 0/00", q_count, q_byte);
        end
        n_cmp++;
        if ({bus_addr, bus_wdata, eu_rdata} !== 44'h0) begin
            n_bad++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", bus_addr, bus_wdata, eu_rdata);
        end
    endtask

    task automatic test_reset_fetch();
        bit ok;
        int busy;
        logic [7:0] pins [4];
        pins = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int k = 0; k < 4; k++) ovr[32'hFFFF0 + k] = pins[k];
        blog.delete();
        m_cs = 16'hFFFF;
        m_ip = 16'h0000;
        reset = 1'b1;
        wait_full(ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL reset_fill: q_count %0d want 4", q_count);
        end
        n_cmp++;
        if (blog.size() != 4) begin
            n_bad++;
            $display("FAIL reset_fetch_n: %0d bus cycles want 4", blog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (blog[k].addr !== addr_of(16'hFFFF, 16'(k)) || blog[k].wr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_fetch_addr%0d: got %h wr %b want %h rd", k, blog[k].addr,
                             blog[k].wr, addr_of(16'hFFFF, 16'(k)));
                end
            end
        end
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus_en) busy++;
            tick();
        end
        n_cmp++;
        if (busy != 0) begin
            n_bad++;
            $display("FAIL full_idle: bus_en high %0d cycles want 0", busy);
        end
        n_cmp++;
        if (q_byte !== 8'hAA) begin
            n_bad++;
            $display("FAIL head_byte: got %h want aa", q_byte);
        end
    endtask

    task automatic test_eu_word_read();
        int ack_at;
        logic [15:0] got;
        ovr[32'h2233F] = 8'h11;
        ovr[32'h12340] = 8'h22;
        blog.delete();
        ack_at = -1;
        got = 16'h0;
        eu_req = 1'b1; eu_rd_wr = 1'b0; eu_word = 1'b1;
        eu_segment = 16'h1234; eu_offset = 16'hFFFF;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (eu_ack && ack_at < 0) begin
                ack_at = i;
                got = eu_rdata;
                eu_req = 1'b0;
            end
        end
        eu_req = 1'b0;
        n_cmp++;
        if (ack_at != 5) begin
            n_bad++;
            $display("FAIL word_latency: ack after %0d cycles want 5", ack_at);
        end
        n_cmp++;
        if (got !== 16'h2211) begin
            n_bad++;
            $display("FAIL word_rdata: got %h want 2211", got);
        end
        n_cmp++;
        if (blog.size() != 2 || blog[0].addr !== 20'h2233F || blog[1].addr !== 20'h12340) begin
            n_bad++;
            $display("FAIL word_wrap_addr: %0d cycles first %h want 2233f then 12340", blog.size(),
                     (blog.size() > 0) ? blog[0].addr : 20'h0);
        end
    endtask

    task automatic test_priority();
        bit ok;
        int seen;
        logic [15:0] ip_next;
        blog.delete();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (q_byte !== memf(addr_of(m_cs, m_ip))) begin
                n_bad++;
                $display("FAIL prio_pop%0d: got %h want %h", k, q_byte, memf(addr_of(m_cs, m_ip)));
            end
            q_pop = 1'b1;
            m_ip = m_ip + 16'd1;
            if (k == 1) begin
                eu_req = 1'b1; eu_rd_wr = 1'b1; eu_word = 1'b0;
                eu_segment = 16'h0000; eu_offset = 16'h0010; eu_wdata = 16'h005A;
            end
            tick();
        end
        q_pop = 1'b0;
        n_cmp++;
        if ({bus_en, bus_rd_wr, bus_addr, bus_wdata, q_count} !== {2'b11, 20'h00010, 8'h5A, 3'd2}) begin
            n_bad++;
            $display("FAIL eu_first: en %b wr %b addr %h data %h count %0d want 1 1 00010 5a 2",
                     bus_en, bus_rd_wr, bus_addr, bus_wdata, q_count);
        end
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (eu_ack) seen = 1;
            tick();
        end
        eu_req = 1'b0;
        for (int i = 0; i < 20 && blog.size() < 2; i++) tick();
        ip_next = m_ip + 16'd2;
        n_cmp++;
        if (blog.size() < 2 || blog[0].addr !== 20'h00010 || blog[0].wr !== 1'b1 ||
            blog[0].wdata !== 8'h5A || blog[1].addr !== addr_of(m_cs, ip_next) || blog[1].wr !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_order: %0d cycles first %h then %h want 00010 wr then %h rd", blog.size(),
                     (blog.size() > 0) ? blog[0].addr : 20'h0,
                     (blog.size() > 1) ? blog[1].addr : 20'h0, addr_of(m_cs, ip_next));
        end
        wait_full(ok);
    endtask

    task automatic test_flush_inflight();
        bit ok;
        blog.delete();
        rdy_force = 1'b1;
        rdy_val = 1'b0;
        q_pop = 1'b1;
        m_ip = m_ip + 16'd1;
        tick(3);
        q_pop = 1'b0;
        flush = 1'b1; new_cs = 16'h0000; new_ip = 16'h0100;
        tick();
        flush = 1'b0;
        m_cs = 16'h0000;
        m_ip = 16'h0100;
        n_cmp++;
        if (q_count !== 3'd0) begin
            n_bad++;
            $display("FAIL flush_count: got %0d want 0", q_count);
        end
        tick(2);
        rdy_val = 1'b1;
        for (int i = 0; i < 30 && blog.size() < 2; i++) tick();
        n_cmp++;
        if (blog.size() < 2 || blog[1].addr !== 20'h00100) begin
            n_bad++;
            $display("FAIL flush_refetch: %0d cycles next addr %h want 00100", blog.size(),
                     (blog.size() > 1) ? blog[1].addr : 20'h0);
        end
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (q_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!ok || q_count !== 3'd1 || q_byte !== memf(20'h00100)) begin
            n_bad++;
            $display("FAIL flush_drop: count %0d byte %h want 1/%h", q_count, q_byte, memf(20'h00100));
        end
        wait_full(ok);
    endtask

    task automatic test_pop_edges();
        bit ok;
        rdy_val = 1'b0;
        flush = 1'b1; new_cs = 16'h0000; new_ip = 16'h0200;
        tick();
        flush = 1'b0;
        m_cs = 16'h0000;
        m_ip = 16'h0200;
        n_cmp++;
        if ({q_valid, q_byte} !== 9'h000) begin
            n_bad++;
            $display("FAIL empty_head: valid %b byte %h want 0/00", q_valid, q_byte);
        end
        q_pop = 1'b1;
        tick();
        q_pop = 1'b0;
        n_cmp++;
        if (q_count !== 3'd0) begin
            n_bad++;
            $display("FAIL pop_empty: count %0d want 0", q_count);
        end
        rdy_val = 1'b1;
        wait_full(ok);
        n_cmp++;
        if (!ok || q_byte !== memf(addr_of(m_cs, m_ip))) begin
            n_bad++;
            $display("FAIL refill: count %0d byte %h want 4/%h", q_count, q_byte, memf(addr_of(m_cs, m_ip)));
        end
        q_pop = 1'b1;
        m_ip = m_ip + 16'd1;
        tick();
        q_pop = 1'b0;
        n_cmp++;
        if (q_count !== 3'd3 || bus_en !== 1'b0) begin
            n_bad++;
            $display("FAIL pop_full: count %0d en %b want 3/0", q_count, bus_en);
        end
        tick();
        n_cmp++;
        if (bus_en !== 1'b1 || bus_rd_wr !== 1'b0 || bus_addr !== addr_of(m_cs, m_ip + 16'd3)) begin
            n_bad++;
            $display("FAIL refetch_after_pop: en %b addr %h want 1/%h", bus_en, bus_addr,
                     addr_of(m_cs, m_ip + 16'd3));
        end
        wait_full(ok);
    endtask

    task automatic test_reset_midword();
        int acks;
        eu_req = 1'b1; eu_rd_wr = 1'b1; eu_word = 1'b1;
        eu_segment = 16'($urandom); eu_offset = 16'($urandom); eu_wdata = 16'($urandom);
        tick(4);
        n_cmp++;
        if (bus_en !== 1'b1 || bus_addr !== addr_of(eu_segment, eu_offset + 16'd1)) begin
            n_bad++;
            $display("FAIL hi_byte_cycle: en %b addr %h want 1/%h", bus_en, bus_addr,
                     addr_of(eu_segment, eu_offset + 16'd1));
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus_en, eu_ack, q_count} !== 5'b0) begin
            n_bad++;
            $display("FAIL async_reset: en %b ack %b count %0d want 0", bus_en, eu_ack, q_count);
        end
        eu_req = 1'b0;
        tick(2);
        reset = 1'b1;
        m_cs = 16'hFFFF;
        m_ip = 16'h0000;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (eu_ack) acks++;
            tick();
        end
        n_cmp++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL no_ack_after_reset: %0d acks want 0", acks);
        end
    endtask

    task automatic random_cycle();
        if ($urandom_range(0, 2) == 0 && q_valid) begin
            n_cmp++;
            if (q_byte !== memf(addr_of(m_cs, m_ip))) begin
                n_bad++;
                $display("FAIL rand_stream: ip %h got %h want %h", m_ip, q_byte, memf(addr_of(m_cs, m_ip)));
            end
            q_pop = 1'b1;
            m_ip = m_ip + 16'd1;
        end else if ($urandom_range(0, 39) == 0) begin
            flush = 1'b1;
            new_cs = 16'($urandom);
            new_ip = 16'($urandom);
            m_cs = new_cs;
            m_ip = new_ip;
        end
        tick();
        q_pop = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_random();
        rdy_force = 1'b0;
        for (int t = 0; t < 60; t++) begin
            logic [15:0] seg, off, off1, want, got;
            bit acked, ok;
            int nw;
            repeat ($urandom_range(0, 5)) random_cycle();
            seg = 16'($urandom);
            off = 16'($urandom_range(0, 7) == 0 ? 16'hFFFF : $urandom);
            off1 = off + 16'd1;
            blog.delete();
            eu_req = 1'b1; eu_rd_wr = 1'($urandom); eu_word = 1'($urandom);
            eu_segment = seg; eu_offset = off; eu_wdata = 16'($urandom);
            acked = 1'b0;
            got = 16'h0;
            for (int i = 0; i < 200 && !acked; i++) begin
                random_cycle();
                if (eu_ack) begin
                    acked = 1'b1;
                    got = eu_rdata;
                end
            end
            eu_req = 1'b0;
            n_cmp++;
            if (!acked) begin
                n_bad++;
                $display("FAIL rand_ack%0d: no ack within 200 cycles", t);
            end else if (eu_rd_wr == 1'b0) begin
                want = eu_word ? {memf(addr_of(seg, off1)), memf(addr_of(seg, off))}
                               : {8'h00, memf(addr_of(seg, off))};
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL rand_read%0d: seg %h off %h word %b got %h want %h",
                             t, seg, off, eu_word, got, want);
                end
            end else begin
                ok = 1'b1;
                nw = 0;
                foreach (blog[k]) begin
                    if (blog[k].wr) begin
                        if (nw == 0 && (blog[k].addr !== addr_of(seg, off) || blog[k].wdata !== eu_wdata[7:0]))
                            ok = 1'b0;
                        if (nw == 1 && (blog[k].addr !== addr_of(seg, off1) || blog[k].wdata !== eu_wdata[15:8]))
                            ok = 1'b0;
                        nw++;
                    end
                end
                if (nw != (eu_word ? 2 : 1)) ok = 1'b0;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL rand_write%0d: seg %h off %h word %b data %h, %0d write cycles seen",
                             t, seg, off, eu_word, eu_wdata, nw);
                end
            end
        end
    endtask

    initial begin
        seed8 = 8'($urandom);
        reset = 1'b0;
        eu_req = 1'b0; eu_rd_wr = 1'b0; eu_word = 1'b0;
        eu_segment = 16'h0; eu_offset = 16'h0; eu_wdata = 16'h0;
        flush = 1'b0; new_cs = 16'h0; new_ip = 16'h0; q_pop = 1'b0;
        rdy_force = 1'b1;
        rdy_val = 1'b1;
        m_cs = 16'hFFFF;
        m_ip = 16'h0000;
        test_reset();
        test_reset_fetch();
        test_eu_word_read();
        test_priority();
        test_flush_inflight();
        test_pop_edges();
        test_reset_midword();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
